// File: rtl/fetch_stage.sv
// Instruction fetch: issues one imem read at a time, buffers {pc, instr} for decode.
// Latency: request 1 cycle after IDLE decision, entry visible 1 cycle after ack; stalls when buffer full.
module fetch_stage #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_incr,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] dec_pc_plus8
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] instr_mem [BUF_DEPTH];
    logic [ADDR_W-1:0] pc_mem    [BUF_DEPTH];
    logic [ADDR_W-1:0] plus8_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              issue;
    logic              push;
    logic              pop;

    assign issue     = (state == IDLE) && !flush && (count < CNT_W'(BUF_DEPTH));
    // Gated by reset so a response landing during reset never advances the PC.
    assign push      = (state == WAIT) && imem_ack && !flush && !reset;
    assign pc_incr   = push;
    assign dec_valid = (count != '0) && !flush;
    assign pop       = dec_valid && dec_ready;

    assign dec_instr    = instr_mem[rd_ptr];
    assign dec_pc       = pc_mem[rd_ptr];
    assign dec_pc_plus8 = plus8_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // pc+8 is stored per entry so an empty buffer after reset reads all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
                plus8_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]    <= imem_addr;
                plus8_mem[wr_ptr] <= imem_addr + ADDR_W'(8);
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
